// File: rtl/tim1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tim1_pkg                                                             |
// | Shared defaults and UEV source encoding for the TIM1 shadow bank.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tim1_pkg;

    localparam int CH_DEF      = 4;
    localparam int WIDTH_DEF   = 16;
    localparam int REP_W_DEF   = 8;
    localparam int RST_VAL_DEF = 0;

    typedef enum logic [0:0] {
        UEV_SRC_OVF = 1'b0,
        UEV_SRC_UG  = 1'b1
    } uev_src_e;

    // Channel-select width; a single-channel bank still needs one bit.
    function automatic int sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tim1_shadow_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tim1_shadow_ch                                                       |
// | One buffer/shadow register pair with preload and write forwarding.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tim1_shadow_ch #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pe,
    input  logic             uev_c,
    output logic [WIDTH-1:0] breg,
    output logic [WIDTH-1:0] sh_reg
);

    always_ff @(posedge clk) begin
        if (rst) begin
            breg   <= RST_VAL;
            sh_reg <= RST_VAL;
        end else begin
            if (wr) begin
                breg <= wr_data;
            end
            // A write landing with a UEV is forwarded so the shadow never sees stale breg.
            if (wr && (!pe || uev_c)) begin
                sh_reg <= wr_data;
            end else if (pe && uev_c) begin
                sh_reg <= breg;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tim1_shadow_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tim1_shadow_bank                                                     |
// | TIM1 preload/shadow bank with UEV generation and update flag.        |
// | Optional repetition counter: define TIM1_SHADOW_REP_EN.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tim1_shadow_bank
    import tim1_pkg::*;
#(
    parameter int               CH      = CH_DEF,
    parameter int               WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEF),
    parameter int               REP_W   = REP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [sel_w(CH)-1:0]  wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [CH-1:0]         pe,
    input  logic                  udis,
    input  logic                  urs,
    input  logic                  ovf,
    input  logic                  ug,
    input  logic                  uif_clr,
`ifdef TIM1_SHADOW_REP_EN
    input  logic                  rep_wr,
    input  logic [REP_W-1:0]      rep_data,
    output logic [REP_W-1:0]      rep_cnt,
`endif
    output logic [CH*WIDTH-1:0]   breg,
    output logic [CH*WIDTH-1:0]   sh_reg,
    output logic                  uev,
    output logic                  uif
);

    localparam int SEL_W = sel_w(CH);

    logic     rep_ok;
    logic     uev_c;
    uev_src_e uev_src;

`ifdef TIM1_SHADOW_REP_EN
    logic [REP_W-1:0] rep_buf;

    assign rep_ok = (rep_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_buf <= '0;
            rep_cnt <= '0;
        end else begin
            if (rep_wr) begin
                rep_buf <= rep_data;
            end
            // Counting continues under udis; an exhausted count reloads silently.
            if (uev_c) begin
                rep_cnt <= rep_buf;
            end else if (ovf) begin
                rep_cnt <= rep_ok ? rep_buf : rep_cnt - 1'b1;
            end
        end
    end
`else
    assign rep_ok = 1'b1;
`endif

    assign uev_c   = ug | (ovf & ~udis & rep_ok);
    // A coincident ovf claims the event, so urs still lets it through.
    assign uev_src = ovf ? UEV_SRC_OVF : UEV_SRC_UG;

    always_ff @(posedge clk) begin
        if (rst) begin
            uev <= 1'b0;
            uif <= 1'b0;
        end else begin
            uev <= uev_c;
            if (uev_c && ((uev_src == UEV_SRC_OVF) || !urs)) begin
                uif <= 1'b1;
            end else if (uif_clr) begin
                uif <= 1'b0;
            end
        end
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic ch_wr;

            assign ch_wr = wr_en && (wr_sel == SEL_W'(i));

            tim1_shadow_ch #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .wr      (ch_wr),
                .wr_data (wr_data),
                .pe      (pe[i]),
                .uev_c   (uev_c),
                .breg    (breg[i*WIDTH +: WIDTH]),
                .sh_reg  (sh_reg[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire
